// File: rtl/jtframe_hsize_ctrl.sv
// rtl/jtframe_hsize_ctrl.sv - frame-synchronous scale/offset/enable commit controller
// Requests are shadowed and committed on a VS rising edge (or timeout), then video is blanked while settling.
module jtframe_hsize_ctrl #(
  parameter int         SETTLE_FR = 2,
  parameter int         OFS_MAX   = 12,
  parameter int         TIMEOUT   = 600000,
  parameter logic [3:0] RST_SCALE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       VS,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_scale,
  input  logic [4:0] req_offset,
  input  logic       req_enable,
  output logic [3:0] scale,
  output logic [4:0] offset,
  output logic       enable,
  output logic       blank,
  output logic       busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT  = '1;
  localparam logic signed [4:0] OFS_HI = 5'(OFS_MAX);
  localparam logic signed [4:0] OFS_LO = 5'(-OFS_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_vsl;
  logic [3:0]    r_sh_scale, w_sh_scale_nx;
  logic [4:0]    r_sh_ofs, w_sh_ofs_nx;
  logic          r_sh_en, w_sh_en_nx;
  logic [3:0]    r_scale, w_scale_nx;
  logic [4:0]    r_ofs, w_ofs_nx;
  logic          r_en, w_en_nx;
  logic          r_blank, w_blank_nx;
  logic [TW-1:0] r_tcnt, w_tcnt_nx;
  logic [3:0]    r_fcnt, w_fcnt_nx;
  logic          w_vs_rise, w_xfer, w_same, w_commit;
  logic [4:0]    w_cl_ofs;

  assign w_vs_rise = pxl_cen & VS & ~r_vsl;
  assign req_ready = (r_state != SETTLE);
  assign w_xfer    = req_valid & req_ready;
  assign busy      = (r_state != IDLE);
  assign scale     = r_scale;
  assign offset    = r_ofs;
  assign enable    = r_en;
  assign blank     = r_blank;

  always_comb begin
    w_cl_ofs = req_offset;
    if ($signed(req_offset) > OFS_HI)      w_cl_ofs = OFS_HI;
    else if ($signed(req_offset) < OFS_LO) w_cl_ofs = OFS_LO;
  end

  assign w_same = (req_scale == r_scale) && (w_cl_ofs == r_ofs) && (req_enable == r_en);

  always_comb begin
    w_state_nx    = r_state;
    w_sh_scale_nx = r_sh_scale;
    w_sh_ofs_nx   = r_sh_ofs;
    w_sh_en_nx    = r_sh_en;
    w_scale_nx    = r_scale;
    w_ofs_nx      = r_ofs;
    w_en_nx       = r_en;
    w_blank_nx    = r_blank;
    w_tcnt_nx     = r_tcnt;
    w_fcnt_nx     = r_fcnt;
    w_commit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_sh_scale_nx = req_scale;
          w_sh_ofs_nx   = w_cl_ofs;
          w_sh_en_nx    = req_enable;
          if (!w_same) begin
            w_state_nx = PEND;
            w_tcnt_nx  = '0;
          end
        end
      end
      PEND: begin
        // a request arriving with the VS edge is committed directly (latest wins)
        if (w_xfer) begin
          w_sh_scale_nx = req_scale;
          w_sh_ofs_nx   = w_cl_ofs;
          w_sh_en_nx    = req_enable;
          w_tcnt_nx     = '0;
          if (w_same)         w_state_nx = IDLE;
          else if (w_vs_rise) w_commit   = 1'b1;
        end else if (w_vs_rise || (pxl_cen && r_tcnt == TO_LAST)) begin
          w_commit = 1'b1;
        end else if (pxl_cen && r_tcnt != TO_SAT) begin
          w_tcnt_nx = r_tcnt + TW'(1);
        end
        if (w_commit) begin
          w_scale_nx = w_sh_scale_nx;
          w_ofs_nx   = w_sh_ofs_nx;
          w_en_nx    = w_sh_en_nx;
          w_fcnt_nx  = 4'(SETTLE_FR);
          if (SETTLE_FR == 0) begin
            w_state_nx = IDLE;
            w_blank_nx = 1'b0;
          end else begin
            w_state_nx = SETTLE;
            w_blank_nx = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (w_vs_rise) begin
          if (r_fcnt <= 4'd1) begin
            w_fcnt_nx  = 4'd0;
            w_blank_nx = 1'b0;
            w_state_nx = IDLE;
          end else begin
            w_fcnt_nx = r_fcnt - 4'd1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vsl      <= 1'b0;
      r_sh_scale <= RST_SCALE;
      r_sh_ofs   <= 5'd0;
      r_sh_en    <= 1'b0;
      r_scale    <= RST_SCALE;
      r_ofs      <= 5'd0;
      r_en       <= 1'b0;
      r_blank    <= 1'b0;
      r_tcnt     <= '0;
      r_fcnt     <= 4'd0;
    end else begin
      r_state    <= w_state_nx;
      if (pxl_cen) r_vsl <= VS;
      r_sh_scale <= w_sh_scale_nx;
      r_sh_ofs   <= w_sh_ofs_nx;
      r_sh_en    <= w_sh_en_nx;
      r_scale    <= w_scale_nx;
      r_ofs      <= w_ofs_nx;
      r_en       <= w_en_nx;
      r_blank    <= w_blank_nx;
      r_tcnt     <= w_tcnt_nx;
      r_fcnt     <= w_fcnt_nx;
    end
  end

endmodule
